// File: rtl/gpio_proto_pkg.sv
// Shared definitions for the 32-bit GPIO command protocol ({data16, func16} out, status/data in).
// Holds the one-hot function codes, the host command opcodes and the host sequencer state encoding.
// No logic; imported by gpio_host_sequencer.
package gpio_proto_pkg;

  // One-hot function codes carried in SELECT_out[15:0]
  localparam logic [15:0] FN_START  = 16'h0001;
  localparam logic [15:0] FN_INQ    = 16'h0002;
  localparam logic [15:0] FN_READ   = 16'h0004;
  localparam logic [15:0] FN_STOP   = 16'h0008;
  localparam logic [15:0] FN_HTRG1  = 16'h0010;
  localparam logic [15:0] FN_LTRG1  = 16'h0020;
  localparam logic [15:0] FN_HTRG2  = 16'h0040;
  localparam logic [15:0] FN_LTRG2  = 16'h0080;
  localparam logic [15:0] FN_CLKDIV = 16'h0100;
  localparam logic [15:0] FN_SHAPE  = 16'h0200;
  localparam logic [15:0] FN_AINSEL = 16'h1000;

  // Host command opcodes; encodings 6 and 7 are reserved
  typedef enum logic [2:0] {
    OP_CFG      = 3'd0,
    OP_START    = 3'd1,
    OP_INQ      = 3'd2,
    OP_READ     = 3'd3,
    OP_READ_ALL = 3'd4,
    OP_STOP     = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_INQ,
    S_RD_STB,
    S_RD_WAIT,
    S_RD_OUT,
    S_GAP,
    S_FIN
  } state_e;

  function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/gpio_host_sequencer.sv
// Host-side sequencer: expands one high-level command into the SELECT word sequence of the GPIO controller.
// Latency: SELECT_out changes the cycle after accept; read word every RD_LAT+1 cycles at best.
// Backpressure: cmd_ready only in IDLE (no queueing); read stream holds rd_valid/rd_data until rd_ready.
// Ports: sys_clk/_RESET_in clock and async active-low reset; cmd_valid/cmd_ready/cmd_op/cmd_func/cmd_data
//   command request; SELECT_out/GPIO_in protocol words; rd_data/rd_valid/rd_ready read stream;
//   cnt_out/full_out last inquiry result; done/err completion pulse and reserved-opcode flag.
module gpio_host_sequencer
  import gpio_proto_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int INQ_LAT     = 2,
  parameter int RD_LAT      = 2
) (
  input  logic        sys_clk,
  input  logic        _RESET_in,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_func,
  input  logic [15:0] cmd_data,
  output logic [31:0] SELECT_out,
  input  logic [31:0] GPIO_in,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [15:0] cnt_out,
  output logic        full_out,
  output logic        done,
  output logic        err
);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] len_q, len_d;
  logic [31:0] drv_q, drv_d;      // word held during DRIVE
  logic [15:0] lat_q, lat_d;      // shared by DRIVE, INQ and RD_WAIT
  logic [15:0] wcnt_q, wcnt_d;    // words still to strobe
  logic [31:0] sel_q, sel_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic        full_q, full_d;
  logic        err_q, err_d;
  logic [15:0] n_all;

  // READ_ALL word count from the inquiry result visible on GPIO_in
  assign n_all = (len_q == 16'h0) ? GPIO_in[15:0] : min16(len_q, GPIO_in[15:0]);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    drv_d      = drv_q;
    lat_d      = lat_q;
    wcnt_d     = wcnt_q;
    sel_d      = 32'h0;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    err_d      = err_q;
    // sel_d is the word for the state being entered, so SELECT_out stays a clean register
    case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (cmd_valid) begin
          op_d  = cmd_op;
          len_d = cmd_data;
          case (cmd_op)
            OP_CFG, OP_START, OP_STOP: begin
              if (cmd_op == OP_CFG)        drv_d = {cmd_data, cmd_func};
              else if (cmd_op == OP_START) drv_d = {16'h0, FN_START};
              else                         drv_d = {16'h0, FN_STOP};
              sel_d   = drv_d;
              lat_d   = 16'(HOLD_CYCLES - 1);
              state_d = S_DRIVE;
            end
            OP_INQ, OP_READ_ALL: begin
              sel_d   = {16'h0, FN_INQ};
              lat_d   = 16'(INQ_LAT);
              state_d = S_INQ;
            end
            OP_READ: begin
              if (cmd_data == 16'h0) begin
                state_d = S_FIN;
              end else begin
                sel_d   = {16'h0, FN_READ};
                wcnt_d  = cmd_data;
                state_d = S_RD_STB;
              end
            end
            default: begin
              // reserved opcode: no bus activity, complete with error
              err_d   = 1'b1;
              state_d = S_FIN;
            end
          endcase
        end
      end
      S_DRIVE: begin
        if (lat_q == 16'h0) begin
          state_d = S_GAP;
        end else begin
          lat_d = lat_q - 16'h1;
          sel_d = drv_q;
        end
      end
      S_INQ: begin
        if (lat_q == 16'h0) begin
          cnt_d  = GPIO_in[15:0];
          full_d = GPIO_in[16];
          if (op_q == OP_READ_ALL) begin
            if (n_all == 16'h0) begin
              state_d = S_FIN;
            end else begin
              sel_d   = {16'h0, FN_READ};
              wcnt_d  = n_all;
              state_d = S_RD_STB;
            end
          end else begin
            state_d = S_GAP;
          end
        end else begin
          lat_d = lat_q - 16'h1;
          sel_d = {16'h0, FN_INQ};
        end
      end
      S_RD_STB: begin
        // strobe is exactly one cycle; capture lands RD_LAT edges after it was driven
        wcnt_d = wcnt_q - 16'h1;
        if (RD_LAT == 1) begin
          rd_data_d  = GPIO_in;
          rd_valid_d = 1'b1;
          state_d    = S_RD_OUT;
        end else begin
          lat_d   = 16'(RD_LAT - 2);
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (lat_q == 16'h0) begin
          rd_data_d  = GPIO_in;
          rd_valid_d = 1'b1;
          state_d    = S_RD_OUT;
        end else begin
          lat_d = lat_q - 16'h1;
        end
      end
      S_RD_OUT: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          if (wcnt_q == 16'h0) begin
            state_d = S_FIN;
          end else begin
            sel_d   = {16'h0, FN_READ};
            state_d = S_RD_STB;
          end
        end
      end
      S_GAP:   state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge _RESET_in) begin
    if (!_RESET_in) begin
      state_q    <= S_IDLE;
      op_q       <= 3'h0;
      len_q      <= 16'h0;
      drv_q      <= 32'h0;
      lat_q      <= 16'h0;
      wcnt_q     <= 16'h0;
      sel_q      <= 32'h0;
      rd_data_q  <= 32'h0;
      rd_valid_q <= 1'b0;
      cnt_q      <= 16'h0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_q      <= len_d;
      drv_q      <= drv_d;
      lat_q      <= lat_d;
      wcnt_q     <= wcnt_d;
      sel_q      <= sel_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign SELECT_out = sel_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign cnt_out    = cnt_q;
  assign full_out   = full_q;
  assign done       = (state_q == S_FIN);
  assign err        = (state_q == S_FIN) && err_q;

endmodule
